conv_out_collector: RTL and testbench

Receive-side counterpart to the convolution pixel stream. It consumes the raster-order output of `Convolution_top` and drops the pipeline warm-up beats. It also drops the wrap-around columns produced at each row boundary. The remaining valid output pixels are re-framed with start-of-frame, end-of-line and end-of-frame markers and buffered in a small FIFO behind a valid/ready handshake, so downstream stages such as the pooling stage or the result dump can stall without losing pixels.

---
 rtl/conv_out_collector_if.sv | 19 +
 rtl/conv_out_collector.sv | 164 ++++++++++++++++
 tb/tb_conv_out_collector.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_out_collector_if.sv
// Output stream of conv_out_collector: framed pixels with valid/ready flow control.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready; the master holds
// out_pixel/out_sof/out_eol/out_eof stable while out_valid=1 and out_ready=0, and never retracts
// out_valid before the transfer.
interface conv_out_collector_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_pixel;
   logic                  out_sof;
   logic                  out_eol;
   logic                  out_eof;

   modport master (output out_valid, output out_pixel, output out_sof, output out_eol,
                   output out_eof, input out_ready);
   modport slave  (input out_valid, input out_pixel, input out_sof, input out_eol,
                   input out_eof, output out_ready);
endinterface

// File: rtl/conv_out_collector.sv
// Collects the valid convolution outputs from a raster stream, frames them (sof/eol/eof) and
// buffers them in a FIFO. Optional COLLECTOR_STATS_EN adds pix_count/pix_sum outputs.
module conv_out_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16,
   parameter int KERNEL     = 3,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  restart,
   conv_out_collector_if.master  ob,
   output logic                  frame_done,
   output logic                  overflow,
   output logic [1:0]            fsm_state
`ifdef COLLECTOR_STATS_EN
   ,
   output logic [31:0]           pix_count,
   output logic [31:0]           pix_sum
`endif
);

   localparam int OW      = IMG_WIDTH - KERNEL + 1;
   localparam int OH      = IMG_HEIGHT - KERNEL + 1;
   localparam int SKIP    = (KERNEL - 1) * IMG_WIDTH + (KERNEL - 1);
   localparam int SKIP_W  = $clog2(SKIP) + 1;
   localparam int COL_W   = $clog2(IMG_WIDTH) + 1;
   localparam int ROW_W   = $clog2(IMG_HEIGHT) + 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = DATA_WIDTH + 3;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [SKIP_W-1:0]   skip_cnt;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;

   logic beat;
   logic last_col;
   logic last_row;
   logic keep;
   logic full;
   logic pop;
   logic push_ok;
   logic drop;

   // restart wins over a same-cycle beat, which is then neither counted nor kept
   assign beat     = valid_in && !restart;
   assign last_col = (col == COL_W'(OW - 1));
   assign last_row = (row == ROW_W'(OH - 1));
   assign keep     = (state_q == ACTIVE) && beat && (col < COL_W'(OW));
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign pop      = ob.out_valid && ob.out_ready;
   assign push_ok  = keep && (!full || pop);
   assign drop     = keep && full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= WARMUP;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WARMUP: begin
            if (restart)                                      state_d = WARMUP;
            else if (valid_in && skip_cnt == SKIP_W'(SKIP - 1)) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (restart)                           state_d = WARMUP;
            else if (keep && last_col && last_row) state_d = DONE;
         end
         DONE: begin
            if (restart) state_d = WARMUP;
         end
         default: state_d = WARMUP;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skip_cnt <= '0;
         col      <= '0;
         row      <= '0;
      end else if (restart) begin
         skip_cnt <= '0;
         col      <= '0;
         row      <= '0;
      end else if (valid_in) begin
         if (state_q == WARMUP) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
         end else if (state_q == ACTIVE) begin
            if (col == COL_W'(IMG_WIDTH - 1)) begin
               col <= '0;
               row <= row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

   // Storage is reset so the head outputs read zero out of reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {(row == '0) && (col == '0), last_col, last_col && last_row, pixel_in};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        overflow <= 1'b0;
      else if (restart) overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
   end

`ifdef COLLECTOR_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_count <= '0;
         pix_sum   <= '0;
      end else if (restart) begin
         pix_count <= '0;
         pix_sum   <= '0;
      end else if (push_ok) begin
         pix_count <= pix_count + 32'd1;
         pix_sum   <= pix_sum + 32'(pixel_in);
      end
   end
`endif

   assign ob.out_valid = (count != '0);
   assign {ob.out_sof, ob.out_eol, ob.out_eof, ob.out_pixel} = mem[rd_ptr];
   assign frame_done   = (state_q == DONE);
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector with W=8, H=6, K=3, FIFO_DEPTH=16.
module tb_conv_out_collector;
   localparam int DW    = 8;
   localparam int W     = 8;
   localparam int H     = 6;
   localparam int K     = 3;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid_in = 1'b0;
   logic [DW-1:0] pixel_in = '0;
   logic          restart = 1'b0;
   logic          frame_done;
   logic          overflow;
   logic [1:0]    fsm_state;
`ifdef COLLECTOR_STATS_EN
   logic [31:0]   pix_count;
   logic [31:0]   pix_sum;
`endif

   conv_out_collector_if #(.DATA_WIDTH(DW)) ob ();

   conv_out_collector #(
      .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pixel_in(pixel_in), .restart(restart),
      .ob(ob), .frame_done(frame_done), .overflow(overflow), .fsm_state(fsm_state)
`ifdef COLLECTOR_STATS_EN
      , .pix_count(pix_count), .pix_sum(pix_sum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   logic [DW+2:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted head beat must match the front of exp_q
   always @(negedge clk) begin
      if (!reset && ob.out_valid && ob.out_ready) begin
         n_pops++;
         if (exp_q.size() == 0) check_eq("extra_pop", 32'd1, 32'd0);
         else check_eq("head", {ob.out_sof, ob.out_eol, ob.out_eof, ob.out_pixel}, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input int v);
      valid_in = 1'b1;
      pixel_in = DW'(v);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; valid_in = 1'b0; restart = 1'b0; pixel_in = '0; ob.out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      exp_q.delete();
      n_pops = 0;
      tick();
   endtask

   // Queue n entries of an output frame whose pixel (0,0) carries value first
   task automatic expect_frame(input int first, input int n);
      int k = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 6; c++) begin
            if (k < n) exp_q.push_back({(r == 0 && c == 0), (c == 5), (r == 3 && c == 5), DW'(first + r * 8 + c)});
            k++;
         end
   endtask

   task automatic drain(input string tag, input int budget);
      valid_in = 1'b0;
      ob.out_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      tick();
      check_eq({tag, "_left"}, exp_q.size(), 0);
      check_eq({tag, "_empty"}, ob.out_valid, 0);
   endtask

   task automatic run_frame1(input string tag);
      n_pops = 0;
      exp_q.delete();
      expect_frame(18, 24);
      ob.out_ready = 1'b1;
      for (int b = 0; b < 56; b++) begin
         drive_beat(b);
         if (b == 17) check_eq({tag, "_pre_valid"}, ob.out_valid, 0);
         if (b == 18) begin
            check_eq({tag, "_first_valid"}, ob.out_valid, 1);
            check_eq({tag, "_first_pix"}, ob.out_pixel, 18);
            check_eq({tag, "_first_sof"}, ob.out_sof, 1);
         end
         if (b == 46) check_eq({tag, "_done_early"}, frame_done, 0);
         if (b == 47) begin
            check_eq({tag, "_done"}, frame_done, 1);
            check_eq({tag, "_state_done"}, fsm_state, 2);
         end
      end
      drain(tag, 10);
      check_eq({tag, "_pops"}, n_pops, 24);
      check_eq({tag, "_ovf"}, overflow, 0);
   endtask

   initial begin
      ob.out_ready = 1'b0;
      tick(); tick();
      check_eq("rst_valid", ob.out_valid, 0);
      check_eq("rst_pixel", ob.out_pixel, 0);
      check_eq("rst_flags", {ob.out_sof, ob.out_eol, ob.out_eof}, 0);
      check_eq("rst_done", frame_done, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_state", fsm_state, 0);
      do_reset();

      // Nominal frame with a free-running sink
      run_frame1("s1");
`ifdef COLLECTOR_STATS_EN
      check_eq("s1_pix_count", pix_count, 24);
      check_eq("s1_pix_sum", pix_sum, 780);
`endif

      // Stalled sink: FIFO fills, later kept pixels are dropped
      do_reset();
      expect_frame(18, 16);
      for (int b = 0; b < 48; b++) begin
         drive_beat(b);
         if (b == 30) check_eq("s2_hold_pix", ob.out_pixel, 18);
         if (b == 37) check_eq("s2_ovf_pre", overflow, 0);
         if (b == 38) check_eq("s2_ovf", overflow, 1);
      end
      check_eq("s2_valid", ob.out_valid, 1);
      check_eq("s2_hold_end", {ob.out_sof, ob.out_pixel}, {1'b1, 8'd18});
      check_eq("s2_done", frame_done, 1);
      drain("s2", 40);
      check_eq("s2_pops", n_pops, 16);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check_eq("s2_rst_ovf", overflow, 0);
      check_eq("s2_rst_done", frame_done, 0);
      check_eq("s2_rst_state", fsm_state, 0);

      // Full FIFO with simultaneous push and pop
      do_reset();
      n_pops = 0;
      expect_frame(18, 17);
      for (int b = 0; b < 38; b++) drive_beat(b);
      ob.out_ready = 1'b1;
      drive_beat(38);
      ob.out_ready = 1'b0;
      check_eq("s3_no_ovf", overflow, 0);
      check_eq("s3_head", ob.out_pixel, 19);
      drive_beat(39);
      check_eq("s3_still_full", overflow, 1);
      for (int b = 40; b < 48; b++) drive_beat(b);
      drain("s3", 40);
      check_eq("s3_pops", n_pops, 17);

      // Restart in ACTIVE at beat 30
      do_reset();
      n_pops = 0;
      ob.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) exp_q.push_back({(c == 0), (c == 5), 1'b0, DW'(18 + c)});
      for (int c = 0; c < 4; c++) exp_q.push_back({3'b000, DW'(26 + c)});
      for (int b = 0; b < 30; b++) drive_beat(b);
      restart = 1'b1;
      drive_beat(30);
      restart = 1'b0;
      check_eq("s4_rearm", fsm_state, 0);
      expect_frame(49, 24);
      for (int b = 31; b < 79; b++) begin
         drive_beat(b);
         if (b == 48) check_eq("s4_pre_valid", ob.out_valid, 0);
         if (b == 49) check_eq("s4_first", {ob.out_valid, ob.out_sof, ob.out_pixel}, {2'b11, 8'd49});
         if (b == 77) check_eq("s4_done_early", frame_done, 0);
      end
      check_eq("s4_done", frame_done, 1);
      drain("s4", 10);
      check_eq("s4_pops", n_pops, 34);

      // Asynchronous reset mid-frame with a loaded FIFO
      do_reset();
      for (int b = 0; b < 40; b++) drive_beat(b);
      check_eq("s5_ovf_before", overflow, 1);
      valid_in = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_eq("s5_valid", ob.out_valid, 0);
      check_eq("s5_pixel", ob.out_pixel, 0);
      check_eq("s5_flags", {ob.out_sof, ob.out_eol, ob.out_eof}, 0);
      check_eq("s5_ovf", overflow, 0);
      check_eq("s5_done", frame_done, 0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      tick();
      check_eq("s5_empty", ob.out_valid, 0);
      run_frame1("s5f");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
